// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults, Q-format constant and the round/limit helpers
// used by the twiddle-multiply stage.
package fft_pkg;

  localparam int NBITS_DEF  = 11;
  localparam int N_DEF      = 32;
  // Coefficients are Q1.(NBITS-2): two integer bits (sign + one), so 1.0 = 2^(NBITS-2).
  localparam int Q_INT_BITS = 2;
  localparam int QF_DEF     = NBITS_DEF - Q_INT_BITS;

  function automatic int q_frac(input int nbits);
    return nbits - Q_INT_BITS;
  endfunction

  // Round half up: add half an LSB of the result, then arithmetic shift.
  function automatic logic signed [63:0] fft_round(input logic signed [63:0] v,
                                                   input int qf);
    logic signed [63:0] half;
    half = 64'sd1 <<< (qf - 1);
    return (v + half) >>> qf;
  endfunction

  // Optional clamp to the signed nb-bit range; without it the caller's
  // truncation to nb bits gives two's-complement wrap.
  function automatic logic signed [63:0] fft_limit(input logic signed [63:0] v,
                                                   input int nb,
                                                   input bit sat_en);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (nb - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (nb - 1));
    if (sat_en && (v > hi)) return hi;
    if (sat_en && (v < lo)) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fft_cmul.sv
// fft_cmul: registered four-product complex multiplier (pipeline stage 2).
// Produces a*c, b*d, a*d, b*c at full 2*NBITS precision; the adder/round
// stage lives in the parent.
module fft_cmul
  import fft_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic                      clk,
  input  logic                      i_en,
  input  logic signed [NBITS-1:0]   i_a,
  input  logic signed [NBITS-1:0]   i_b,
  input  logic signed [NBITS-1:0]   i_c,
  input  logic signed [NBITS-1:0]   i_d,
  output logic signed [2*NBITS-1:0] o_ac,
  output logic signed [2*NBITS-1:0] o_bd,
  output logic signed [2*NBITS-1:0] o_ad,
  output logic signed [2*NBITS-1:0] o_bc
);

  logic signed [2*NBITS-1:0] r_ac_p1;
  logic signed [2*NBITS-1:0] r_bd_p1;
  logic signed [2*NBITS-1:0] r_ad_p1;
  logic signed [2*NBITS-1:0] r_bc_p1;

  // Stage 2 boundary: register the four partial products when the pipe advances.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_ac_p1 <= (2*NBITS)'(i_a) * (2*NBITS)'(i_c);
      r_bd_p1 <= (2*NBITS)'(i_b) * (2*NBITS)'(i_d);
      r_ad_p1 <= (2*NBITS)'(i_a) * (2*NBITS)'(i_d);
      r_bc_p1 <= (2*NBITS)'(i_b) * (2*NBITS)'(i_c);
    end
  end

  assign o_ac = r_ac_p1;
  assign o_bd = r_bd_p1;
  assign o_ad = r_ad_p1;
  assign o_bc = r_bc_p1;

endmodule

// File: rtl/fft_twiddle_stage.sv
// fft_twiddle_stage: 3-stage streaming complex multiply of each sample by the
// twiddle of its slot, with valid/ready flow control and frame slot counter.
// Build option: define FFT_TWIDDLE_SAT_EN to clamp results instead of wrapping.
module fft_twiddle_stage
  import fft_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int N     = N_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NBITS*N*2-1:0]      coeff_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [NBITS-1:0]   in_re,
  input  logic signed [NBITS-1:0]   in_im,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [NBITS-1:0]   out_re,
  output logic signed [NBITS-1:0]   out_im,
  output logic                      out_last,
  output logic [$clog2(N)-1:0]      out_idx
);

  localparam int IDXW = $clog2(N);
  localparam int QF   = q_frac(NBITS);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);
`ifdef FFT_TWIDDLE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic                      w_adv;
  logic                      w_accept;
  logic [2*NBITS-1:0]        w_slot;
  logic [IDXW-1:0]           r_idx;

  logic                      r_vld_p0, r_vld_p1, r_vld_p2;
  logic signed [NBITS-1:0]   r_a_p0, r_b_p0, r_c_p0, r_d_p0;
  logic                      r_last_p0, r_last_p1, r_last_p2;
  logic [IDXW-1:0]           r_idx_p0, r_idx_p1, r_idx_p2;
  logic signed [2*NBITS-1:0] w_ac, w_bd, w_ad, w_bc;
  logic signed [2*NBITS:0]   w_re_sum, w_im_sum;
  logic signed [NBITS-1:0]   w_re_rnd, w_im_rnd;
  logic signed [NBITS-1:0]   r_re_p2, r_im_p2;

  // The whole pipe moves together unless the output holds an unaccepted result.
  assign w_adv    = !r_vld_p2 || out_ready;
  assign in_ready = w_adv;
  assign w_accept = in_valid && w_adv;
  assign w_slot   = coeff_data[int'(r_idx)*2*NBITS +: 2*NBITS];

  // Slot counter and stage valids; in_last restarts the frame at slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_accept) begin
        if (in_last || (r_idx == IDX_LAST)) r_idx <= '0;
        else                                r_idx <= r_idx + 1'b1;
      end
      if (w_adv) begin
        r_vld_p0 <= in_valid;
        r_vld_p1 <= r_vld_p0;
        r_vld_p2 <= r_vld_p1;
      end
    end
  end

  // Stage 1 boundary: capture sample, its slot's coefficient and side-band.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_a_p0    <= in_re;
      r_b_p0    <= in_im;
      r_c_p0    <= w_slot[2*NBITS-1:NBITS];
      r_d_p0    <= w_slot[NBITS-1:0];
      r_last_p0 <= in_last;
      r_idx_p0  <= r_idx;
    end
  end

  fft_cmul #(.NBITS(NBITS)) u_cmul (
    .clk  (clk),
    .i_en (w_adv),
    .i_a  (r_a_p0),
    .i_b  (r_b_p0),
    .i_c  (r_c_p0),
    .i_d  (r_d_p0),
    .o_ac (w_ac),
    .o_bd (w_bd),
    .o_ad (w_ad),
    .o_bc (w_bc)
  );

  // Stage 2 boundary: side-band follows the products held inside fft_cmul.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_last_p1 <= r_last_p0;
      r_idx_p1  <= r_idx_p0;
    end
  end

  assign w_re_sum = $signed({w_ac[2*NBITS-1], w_ac}) - $signed({w_bd[2*NBITS-1], w_bd});
  assign w_im_sum = $signed({w_ad[2*NBITS-1], w_ad}) + $signed({w_bc[2*NBITS-1], w_bc});
  assign w_re_rnd = NBITS'(fft_limit(fft_round(64'(w_re_sum), QF), NBITS, SAT_EN));
  assign w_im_rnd = NBITS'(fft_limit(fft_round(64'(w_im_sum), QF), NBITS, SAT_EN));

  // Stage 3 boundary: rounded/limited result and side-band at the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_re_p2   <= '0;
      r_im_p2   <= '0;
      r_last_p2 <= 1'b0;
      r_idx_p2  <= '0;
    end else if (w_adv) begin
      r_re_p2   <= w_re_rnd;
      r_im_p2   <= w_im_rnd;
      r_last_p2 <= r_last_p1;
      r_idx_p2  <= r_idx_p1;
    end
  end

  assign out_valid = r_vld_p2;
  assign out_re    = r_re_p2;
  assign out_im    = r_im_p2;
  assign out_last  = r_last_p2;
  assign out_idx   = r_idx_p2;

endmodule

// File: tb/tb_fft_twiddle_stage.sv
// Directed testbench for fft_twiddle_stage (NBITS=11, N=32).
module tb_fft_twiddle_stage;

  localparam int NB = 11;
  localparam int NN = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NB*NN*2-1:0]     coeff_data = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [NB-1:0]   in_re = '0;
  logic signed [NB-1:0]   in_im = '0;
  logic                   in_last = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic signed [NB-1:0]   out_re;
  logic signed [NB-1:0]   out_im;
  logic                   out_last;
  logic [4:0]             out_idx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic signed [NB-1:0] re;
    logic signed [NB-1:0] im;
    logic                 last;
    logic [4:0]           idx;
  } out_t;
  out_t q[$];

  fft_twiddle_stage #(.NBITS(NB), .N(NN)) dut (
    .clk        (clk),
    .rst        (rst),
    .coeff_data (coeff_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_last   (out_last),
    .out_idx    (out_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer; sampled mid-cycle, the transfer completes at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      q.push_back('{re: out_re, im: out_im, last: out_last, idx: out_idx});
  end

  task automatic set_slot(input int k, input logic signed [NB-1:0] c, input logic signed [NB-1:0] d);
    coeff_data[2*NB*k +: 2*NB] = {c, d};
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic signed [NB-1:0] re, input logic signed [NB-1:0] im,
                      input logic last, output bit ok);
    bit acc;
    in_valid = 1'b1; in_re = re; in_im = im; in_last = last; ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_outs(input int n, output bit ok);
    for (int t = 0; t < 200; t++) begin
      if (q.size() >= n) break;
      @(negedge clk);
    end
    ok = (q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_re !== 11'sd0) begin n_err++; $display("FAIL reset_out_re: got %0d expected 0", out_re); end
    n_cmp++; if (out_im !== 11'sd0) begin n_err++; $display("FAIL reset_out_im: got %0d expected 0", out_im); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    n_cmp++; if (out_idx !== 5'd0) begin n_err++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    q.delete();
  endtask

  task automatic test_identity();
    set_slot(0, 11'sd512, 11'sd0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_re = 11'sd100; in_im = -11'sd50; in_last = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ident_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ident_early_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ident_latency_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_re !== 11'sd100) begin n_err++; $display("FAIL ident_re: got %0d expected 100", out_re); end
    n_cmp++; if (out_im !== -11'sd50) begin n_err++; $display("FAIL ident_im: got %0d expected -50", out_im); end
    n_cmp++; if (out_idx !== 5'd0) begin n_err++; $display("FAIL ident_idx: got %0d expected 0", out_idx); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ident_single_valid: got %b expected 0", out_valid); end
    q.delete();
  endtask

  task automatic test_minus_j();
    bit ok;
    set_slot(1, 11'sd0, -11'sd512);
    @(posedge clk); #1;
    send(11'sd100, 11'sd50, 1'b0, ok);
    idle();
    wait_outs(1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mj_timeout: got %0d outputs expected 1", q.size()); end
    else begin
      n_cmp++; if (q[0].re !== 11'sd50) begin n_err++; $display("FAIL mj_re: got %0d expected 50", q[0].re); end
      n_cmp++; if (q[0].im !== -11'sd100) begin n_err++; $display("FAIL mj_im: got %0d expected -100", q[0].im); end
      n_cmp++; if (q[0].idx !== 5'd1) begin n_err++; $display("FAIL mj_idx: got %0d expected 1", q[0].idx); end
    end
    q.delete();
  endtask

  task automatic test_overflow();
    bit ok;
    logic signed [NB-1:0] exp_re;
`ifdef FFT_TWIDDLE_SAT_EN
    exp_re = -11'sd1024;
`else
    exp_re = 11'sd600;
`endif
    set_slot(2, 11'sd362, -11'sd362);
    send(-11'sd1024, -11'sd1024, 1'b0, ok);
    idle();
    wait_outs(1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_timeout: got %0d outputs expected 1", q.size()); end
    else begin
      n_cmp++; if (q[0].re !== exp_re) begin n_err++; $display("FAIL ovf_re: got %0d expected %0d", q[0].re, exp_re); end
      n_cmp++; if (q[0].im !== 11'sd0) begin n_err++; $display("FAIL ovf_im: got %0d expected 0", q[0].im); end
      n_cmp++; if (q[0].idx !== 5'd2) begin n_err++; $display("FAIL ovf_idx: got %0d expected 2", q[0].idx); end
    end
    q.delete();
  endtask

  task automatic test_wrap_last();
    bit ok;
    int start;
    for (int k = 0; k < NN; k++) set_slot(k, 11'sd512, 11'sd0);
    do_reset();
    start = cyc;
    for (int k = 0; k < 33; k++) send(NB'(k*3 - 40), NB'(-k), 1'b0, ok);
    n_cmp++; if (cyc - start !== 33) begin n_err++; $display("FAIL wrap_throughput: got %0d cycles expected 33", cyc - start); end
    idle();
    wait_outs(33, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_timeout: got %0d outputs expected 33", q.size()); end
    else begin
      for (int i = 0; i < 33; i++) begin
        n_cmp++; if (q[i].idx !== 5'(i % 32)) begin n_err++; $display("FAIL wrap_idx[%0d]: got %0d expected %0d", i, q[i].idx, i % 32); end
        n_cmp++; if (q[i].re !== NB'(i*3 - 40) || q[i].im !== NB'(-i)) begin
          n_err++; $display("FAIL wrap_data[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, q[i].re, q[i].im, i*3 - 40, -i);
        end
        n_cmp++; if (q[i].last !== 1'b0) begin n_err++; $display("FAIL wrap_last[%0d]: got %b expected 0", i, q[i].last); end
      end
    end
    do_reset();
    for (int k = 0; k < 7; k++) send(NB'(k + 1), 11'sd0, (k == 4), ok);
    idle();
    wait_outs(7, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL last_timeout: got %0d outputs expected 7", q.size()); end
    else begin
      for (int i = 0; i < 7; i++) begin
        n_cmp++; if (q[i].idx !== 5'((i < 5) ? i : i - 5)) begin
          n_err++; $display("FAIL last_idx[%0d]: got %0d expected %0d", i, q[i].idx, (i < 5) ? i : i - 5);
        end
        n_cmp++; if (q[i].last !== (i == 4)) begin n_err++; $display("FAIL last_flag[%0d]: got %b expected %b", i, q[i].last, (i == 4)); end
      end
    end
    q.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    fork
      begin
        bit sok;
        for (int k = 0; k < 10; k++) send(NB'(10*k + 5), NB'(-10*k), 1'b0, sok);
        idle();
      end
      begin
        logic signed [NB-1:0] s_re, s_im;
        logic [4:0] s_idx;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        s_re = out_re; s_im = out_im; s_idx = out_idx;
        n_cmp++; if (out_valid !== 1'b1 || out_re !== 11'sd25 || out_idx !== 5'd2) begin
          n_err++; $display("FAIL bp_held: got v=%b re=%0d idx=%0d expected v=1 re=25 idx=2", out_valid, out_re, out_idx);
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        repeat (3) begin
          @(negedge clk);
          n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_hold: got %b expected 0", in_ready); end
          n_cmp++; if (out_re !== s_re || out_im !== s_im || out_idx !== s_idx || out_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_frozen: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", out_re, out_im, out_idx, s_re, s_im, s_idx);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_outs(10, ok);
    repeat (5) @(negedge clk);
    n_cmp++; if (q.size() !== 10) begin n_err++; $display("FAIL bp_count: got %0d outputs expected 10", q.size()); end
    for (int i = 0; i < 10 && i < q.size(); i++) begin
      n_cmp++; if (q[i].re !== NB'(10*i + 5) || q[i].im !== NB'(-10*i) || q[i].idx !== 5'(i)) begin
        n_err++; $display("FAIL bp_order[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", i, q[i].re, q[i].im, q[i].idx, 10*i + 5, -10*i, i);
      end
    end
    q.delete();
  endtask

  task automatic test_reset_midframe();
    bit ok;
    do_reset();
    set_slot(0, 11'sd512, 11'sd0);
    set_slot(3, 11'sd0, 11'sd512);
    send(11'sd1, 11'sd1, 1'b0, ok);
    send(11'sd2, 11'sd2, 1'b0, ok);
    send(11'sd3, 11'sd3, 1'b0, ok);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_re !== 11'sd0 || out_im !== 11'sd0 || out_last !== 1'b0 || out_idx !== 5'd0) begin
      n_err++; $display("FAIL rstmid_outs: got (%0d,%0d,%b,%0d) expected (0,0,0,0)", out_re, out_im, out_last, out_idx);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    q.delete();
    @(posedge clk); #1;
    send(11'sd7, -11'sd9, 1'b0, ok);
    idle();
    wait_outs(1, ok);
    repeat (5) @(negedge clk);
    n_cmp++; if (q.size() !== 1) begin n_err++; $display("FAIL rstmid_count: got %0d outputs expected 1", q.size()); end
    if (q.size() >= 1) begin
      n_cmp++; if (q[0].idx !== 5'd0 || q[0].re !== 11'sd7 || q[0].im !== -11'sd9) begin
        n_err++; $display("FAIL rstmid_first: got (%0d,%0d,%0d) expected (7,-9,0)", q[0].re, q[0].im, q[0].idx);
      end
    end
    q.delete();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_minus_j();
    test_overflow();
    test_wrap_last();
    test_backpressure();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_twiddle_stage.md
FFT_TWIDDLE_STAGE -- requirements
Module: fft_twiddle_stage

Interface
REQ-001 SHALL have parameter NBITS, default 11: signed width of each real/imag sample and coefficient component.
REQ-002 SHALL have parameter N, default 32: number of twiddle slots per frame.
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port coeff_data, input, NBITS*N*2: packed twiddles; slot k = [2*NBITS*(k+1)-1 : 2*NBITS*k]; upper NBITS = real, lower NBITS = imag; format Q1.(NBITS-2), 1.0 = 2^(NBITS-2).
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_re and in_im (input, NBITS each, signed), in_last (input, 1).
REQ-007 SHALL have ports out_valid (input to downstream, output, 1), out_ready (input, 1), out_re and out_im (output, NBITS each, signed), out_last (output, 1), out_idx (output, clog2(N)): slot used.

Function
REQ-008 SHALL accept a sample when in_valid && in_ready, and emit it when out_valid && out_ready.
REQ-009 SHALL keep slot counter idx; accepted sample uses slot idx; idx then increments, wrapping N-1 -> 0.
REQ-010 SHALL force idx to 0 after an accepted sample with in_last=1, regardless of count.
REQ-011 SHALL compute re = a*c - b*d, im = a*d + b*c, (a,b)=input, (c,d)=slot; full-precision 2*NBITS+1 bit sums.
REQ-012 SHALL round by adding 2^(NBITS-3) then arithmetic right-shift by NBITS-2 (round half up).
REQ-013 SHALL pipeline in 3 stages: register inputs+coeff select; register four products; register sums, round, limit. Latency exactly 3 cycles with out_ready held high.
REQ-014 SHALL stall the whole pipeline when the output stage holds valid data and out_ready=0; advance enable = !out_valid || out_ready.
REQ-015 SHALL drive in_ready = advance enable (combinational; no input buffering).
REQ-016 SHALL carry in_last and idx alongside data through every stage, aligned with out_re/out_im.
REQ-017 SHALL sustain one sample per cycle when in_valid and out_ready are continuously high.
REQ-018 SHALL hold out_re/out_im/out_last/out_idx stable while out_valid=1 and out_ready=0.
REQ-019 SHALL treat coeff_data as static but sample it at stage 1, so a change affects only later-accepted samples.

Reset
REQ-020 SHALL on rst clear idx, all stage valids, out_valid, out_re, out_im, out_last, out_idx to 0.
REQ-021 SHALL discard in-flight samples on rst mid-frame; in_ready = 1 the cycle after rst deasserts.

Configuration
REQ-022 SHALL support macro FFT_TWIDDLE_SAT_EN: defined -> rounded results clamp to [-2^(NBITS-1), 2^(NBITS-1)-1]; undefined -> low NBITS bits kept (two's-complement wrap).

Structure
REQ-023 SHALL place NBITS/N defaults, Q-format constant (NBITS-2), and round/saturate function in shared package fft_pkg.
REQ-024 SHALL instantiate one sub-module fft_cmul (registered four-product complex multiplier, stage 2) used by stages 2-3.

Verification
REQ-025 SHALL test identity: slot 0 = (512,0), in=(100,-50) -> out=(100,-50), out_idx=0, exactly 3 cycles after accept.
REQ-026 SHALL test -j: slot 1 = (0,-512), in=(100,50) -> out=(50,-100), out_idx=1.
REQ-027 SHALL test overflow: slot = (362,-362), in=(-1024,-1024) -> out=(-1024,0) with FFT_TWIDDLE_SAT_EN; re=(-1448 wrapped)=600, im=0 without.
REQ-028 SHALL test wrap/last: 32 samples -> out_idx 0..31 then 0; in_last on 5th sample -> next sample uses idx 0, out_last set on 5th output only.
REQ-029 SHALL test backpressure: out_ready low 4 cycles mid-stream -> in_ready low, outputs frozen, no loss/duplication, order preserved.
REQ-030 SHALL test reset mid-frame: rst with 3 samples in flight -> out_valid=0 next cycle, idx=0, first new sample uses slot 0.
